sqrt2_host: RTL and testbench
=============================

SQRT2_HOST -- requirements
Module: sqrt2_host

Interface
REQ-001 Parameter TIMEOUT_CYCLES, default 32, SHALL set the maximum number of WAIT cycles before a request is aborted.
REQ-002 Parameter W, default 16, SHALL set the width of the FP16 data path, fixed at 16 in this release.
REQ-003 CLK  input  1  SHALL be the single clock; all state changes occur on its rising edge.
REQ-004 RST_N  input  1  SHALL be the asynchronous, active-low reset.
REQ-005 REQ_VALID  input  1  SHALL indicate that a host request operand is offered.
REQ-006 REQ_READY  output  1  SHALL indicate that the block accepts a request this cycle.
REQ-007 REQ_DATA  input  16  SHALL carry the FP16 operand.
REQ-008 RSP_VALID  output  1  SHALL indicate that a response is held.
REQ-009 RSP_READY  input  1  SHALL indicate that the host consumes the response.
REQ-010 RSP_DATA  output  16  SHALL carry the FP16 result captured from IO_DATA.
REQ-011 RSP_FLAGS  output  3  SHALL carry {NAN, PINF, NINF} as captured.
REQ-012 RSP_TIMEOUT  output  1  SHALL flag that the response was aborted by timeout.
REQ-013 ENABLE  output  1  SHALL drive the sqrt2 engine enable.
REQ-014 IO_DATA  inout  16  SHALL be the shared operand/result bus, driven by this block only in DRIVE and otherwise high-Z.
REQ-015 RESULT, IS_NAN, IS_PINF, IS_NINF  input  1 each  SHALL be the engine status lines, valid while RESULT=1.

Function
REQ-016 The FSM SHALL have the states IDLE, DRIVE, WAIT and RESP, one-hot or binary.
- IDLE: ENABLE=0, bus Z, REQ_READY=1.
- On REQ_VALID&&REQ_READY: latch REQ_DATA, go to DRIVE.
REQ-017 DRIVE SHALL last exactly one cycle with ENABLE=1 and IO_DATA=latched operand, then go to WAIT.
REQ-018 WAIT SHALL hold ENABLE=1 with the bus Z and increment a watchdog counter that is cleared on entry.
REQ-019 In WAIT, RESULT=1 at a rising edge SHALL capture IO_DATA into RSP_DATA and the IS_* lines into RSP_FLAGS, clear RSP_TIMEOUT, and go to RESP.
REQ-020 In WAIT, the counter reaching TIMEOUT_CYCLES without RESULT SHALL set RSP_DATA=16'h0000, RSP_FLAGS=0, RSP_TIMEOUT=1, and go to RESP.
- RESULT on the same edge as the timeout wins.
REQ-021 RESP SHALL hold ENABLE=0 and RSP_VALID=1, with RSP_* stable, until RSP_READY=1; it then goes to IDLE.
REQ-022 REQ_READY SHALL be 1 only in IDLE, giving one outstanding request at a time.
REQ-023 ENABLE SHALL be low for at least 2 consecutive cycles (RESP plus IDLE) between operations, guaranteeing the engine restart.
REQ-024 RESULT asserted in IDLE, DRIVE or RESP SHALL be ignored.
REQ-025 Latency SHALL be: request accepted at edge k, ENABLE high from k, engine samples at k+1, RSP_VALID rises on the edge after RESULT is first seen.
REQ-026 The bus output enable SHALL be a registered decode of the DRIVE state, so IO_DATA is never driven outside DRIVE.
REQ-027 RSP_VALID&&RSP_READY in the same cycle as REQ_VALID SHALL NOT accept the new request until IDLE.

Reset
REQ-028 RST_N=0 SHALL force the following immediately, including mid-operation:
- state IDLE, ENABLE=0, IO_DATA Z;
- RSP_VALID=0, RSP_DATA=0, RSP_FLAGS=0, RSP_TIMEOUT=0;
- counter=0, REQ_READY=1 (while RST_N=1).
REQ-029 A request interrupted by reset SHALL be dropped and never produce a response.

Structure
REQ-030 Package sqrt2_pkg SHALL hold:
- the state enum;
- the flag struct {nan, pinf, ninf};
- FP16 constants FP16_ONE=3C00, FP16_PINF=7C00, FP16_QNAN=7E00.
REQ-031 One sub-module, sqrt2_wdog (clearable up-counter with terminal flag), SHALL implement the timeout.
- All other logic is flat in sqrt2_host.

Verification
REQ-032 The bench SHALL connect the block to sqrt2 and cover:
- REQ_DATA=3C00 -> RSP_DATA=3C00, RSP_FLAGS=000, RSP_TIMEOUT=0; IO_DATA driven exactly one cycle.
- REQ_DATA=4000 -> RSP_DATA=3DA8, RSP_FLAGS=000.
- REQ_DATA=7C00 -> RSP_DATA=7C00, RSP_FLAGS=010; REQ_DATA=7E00 -> RSP_FLAGS=100.
- Engine model that never asserts RESULT -> RSP_TIMEOUT=1, RSP_DATA=0000 after exactly 32 WAIT cycles.
- RSP_READY held low 5 cycles -> RSP_VALID and RSP_DATA stable, REQ_READY=0, ENABLE=0 throughout.
- RST_N pulsed low mid-WAIT -> ENABLE=0 and bus Z immediately, no RSP_VALID; next request 3C00 completes normally.

Source files
------------

// File: rtl/sqrt2_pkg.sv
// Shared types and constants for the sqrt2 host adapter.
package sqrt2_pkg;

    // Host-side sequencer states.
    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StDrive = 2'd1,
        StWait  = 2'd2,
        StResp  = 2'd3
    } state_e;

    // Result classification as reported by the engine, MSB first.
    typedef struct packed {
        logic nan;
        logic pinf;
        logic ninf;
    } flags_t;

    localparam logic [15:0] FP16_ONE  = 16'h3C00;
    localparam logic [15:0] FP16_PINF = 16'h7C00;
    localparam logic [15:0] FP16_QNAN = 16'h7E00;

endpackage

// File: rtl/sqrt2_wdog.sv
// Clearable up-counter with a terminal flag, used to abort a stalled engine.
module sqrt2_wdog #(
    parameter int unsigned LIMIT = 32  // must be >= 1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr_i,
    input  logic en_i,
    output logic done_o
);

    localparam int unsigned CW = $clog2(LIMIT + 1);

    logic [CW-1:0] count_q;
    logic [CW-1:0] count_d;

    // Clear has priority; count only while enabled.
    always_comb begin
        count_d = count_q;
        if (clr_i) begin
            count_d = '0;
        end else if (en_i) begin
            count_d = count_q + CW'(1);
        end
    end

    // Counter state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    // Terminal on the edge where the counter would reach LIMIT.
    assign done_o = en_i && (count_q == CW'(LIMIT - 1));

endmodule

// File: rtl/sqrt2_host.sv
// Host adapter for the sqrt2 engine: accepts one FP16 operand at a time, drives it onto the shared
// bus for one cycle, waits for the engine result (or a watchdog timeout) and holds the response
// until the host takes it.
module sqrt2_host
    import sqrt2_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 32,
    parameter int unsigned W              = 16  // FP16 only in this release
) (
    input  logic         clk,
    input  logic         rst_n,
    // Request channel
    input  logic         req_valid_i,
    output logic         req_ready_o,
    input  logic [W-1:0] req_data_i,
    // Response channel
    output logic         rsp_valid_o,
    input  logic         rsp_ready_i,
    output logic [W-1:0] rsp_data_o,
    output logic [2:0]   rsp_flags_o,
    output logic         rsp_timeout_o,
    // Engine side
    output logic         enable_o,
    inout  wire  [W-1:0] io_data_io,
    input  logic         result_i,
    input  logic         is_nan_i,
    input  logic         is_pinf_i,
    input  logic         is_ninf_i
);

    state_e         state_q;
    logic [W-1:0]   op_q;
    logic           enable_q;
    logic           oe_q;
    logic           req_ready_q;
    logic           rsp_valid_q;
    logic [W-1:0]   rsp_data_q;
    flags_t         rsp_flags_q;
    logic           rsp_timeout_q;
    logic           wdog_done;

    // The only way into WAIT is through DRIVE, so clearing there clears on WAIT entry.
    sqrt2_wdog #(
        .LIMIT (TIMEOUT_CYCLES)
    ) u_wdog (
        .clk    (clk),
        .rst_n  (rst_n),
        .clr_i  (state_q == StDrive),
        .en_i   (state_q == StWait),
        .done_o (wdog_done)
    );

    // Sequencer with all outputs registered alongside the state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= StIdle;
            op_q          <= '0;
            enable_q      <= 1'b0;
            oe_q          <= 1'b0;
            req_ready_q   <= 1'b1;
            rsp_valid_q   <= 1'b0;
            rsp_data_q    <= '0;
            rsp_flags_q   <= '0;
            rsp_timeout_q <= 1'b0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (req_valid_i && req_ready_q) begin
                        op_q        <= req_data_i;
                        state_q     <= StDrive;
                        enable_q    <= 1'b1;
                        oe_q        <= 1'b1;
                        req_ready_q <= 1'b0;
                    end
                end
                StDrive: begin
                    // Engine samples the operand on this edge; release the bus for its result.
                    state_q <= StWait;
                    oe_q    <= 1'b0;
                end
                StWait: begin
                    // A result arriving on the timeout edge still wins.
                    if (result_i) begin
                        rsp_data_q    <= io_data_io;
                        rsp_flags_q   <= '{nan: is_nan_i, pinf: is_pinf_i, ninf: is_ninf_i};
                        rsp_timeout_q <= 1'b0;
                        rsp_valid_q   <= 1'b1;
                        enable_q      <= 1'b0;
                        state_q       <= StResp;
                    end else if (wdog_done) begin
                        rsp_data_q    <= '0;
                        rsp_flags_q   <= '0;
                        rsp_timeout_q <= 1'b1;
                        rsp_valid_q   <= 1'b1;
                        enable_q      <= 1'b0;
                        state_q       <= StResp;
                    end
                end
                StResp: begin
                    // Go through IDLE before the next accept, so ENABLE stays low two cycles.
                    if (rsp_ready_i) begin
                        rsp_valid_q <= 1'b0;
                        req_ready_q <= 1'b1;
                        state_q     <= StIdle;
                    end
                end
                default: begin
                    state_q <= StIdle;
                end
            endcase
        end
    end

    assign io_data_io    = oe_q ? op_q : {W{1'bz}};
    assign enable_o      = enable_q;
    assign req_ready_o   = req_ready_q;
    assign rsp_valid_o   = rsp_valid_q;
    assign rsp_data_o    = rsp_data_q;
    assign rsp_flags_o   = rsp_flags_q;
    assign rsp_timeout_o = rsp_timeout_q;

    // Registered outputs must agree with the state they decode.
    a_oe_only_drive : assert property (@(posedge clk) disable iff (!rst_n)
        oe_q == (state_q == StDrive));
    a_ready_only_idle : assert property (@(posedge clk) disable iff (!rst_n)
        req_ready_q == (state_q == StIdle));
    a_enable_busy : assert property (@(posedge clk) disable iff (!rst_n)
        enable_q == (state_q == StDrive || state_q == StWait));
    a_valid_resp : assert property (@(posedge clk) disable iff (!rst_n)
        rsp_valid_q == (state_q == StResp));

endmodule

// File: tb/tb_sqrt2_host.sv
// Directed bench for sqrt2_host with a behavioural sqrt2 engine on the shared bus.
module tb_sqrt2_host;
    import sqrt2_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic [15:0] req_data = '0;
    logic        rsp_valid;
    logic        rsp_ready = 1'b0;
    logic [15:0] rsp_data;
    logic [2:0]  rsp_flags;
    logic        rsp_timeout;
    logic        enable;
    wire  [15:0] io_bus;
    logic        result;

    // Engine model state
    logic        eng_oe = 1'b0;
    logic [15:0] eng_drv = '0;
    logic        eng_result = 1'b0;
    logic        eng_nan = 1'b0;
    logic        eng_pinf = 1'b0;
    logic        eng_ninf = 1'b0;
    logic        eng_busy = 1'b0;
    logic [15:0] eng_op = '0;
    int          eng_cnt = 0;
    int          eng_lat = 2;
    bit          eng_mute = 1'b0;
    logic        stray_result = 1'b0;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    assign io_bus = eng_oe ? eng_drv : 16'hzzzz;
    assign result = eng_result | stray_result;

    sqrt2_host #(
        .TIMEOUT_CYCLES (32),
        .W              (16)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .req_valid_i   (req_valid),
        .req_ready_o   (req_ready),
        .req_data_i    (req_data),
        .rsp_valid_o   (rsp_valid),
        .rsp_ready_i   (rsp_ready),
        .rsp_data_o    (rsp_data),
        .rsp_flags_o   (rsp_flags),
        .rsp_timeout_o (rsp_timeout),
        .enable_o      (enable),
        .io_data_io    (io_bus),
        .result_i      (result),
        .is_nan_i      (eng_nan),
        .is_pinf_i     (eng_pinf),
        .is_ninf_i     (eng_ninf)
    );

    // Hand-computed sqrt table: {nan, pinf, ninf, data}.
    function automatic logic [18:0] sqrt_model(input logic [15:0] x);
        case (x)
            16'h3C00: sqrt_model = {3'b000, 16'h3C00};
            16'h4000: sqrt_model = {3'b000, 16'h3DA8};
            16'h7C00: sqrt_model = {3'b010, 16'h7C00};
            default:  sqrt_model = {3'b100, 16'h7E00};
        endcase
    endfunction

    // Engine: samples the bus on the first edge with ENABLE high, answers eng_lat+1 edges later.
    always @(posedge clk) begin
        if (!enable) begin
            eng_busy   <= 1'b0;
            eng_oe     <= 1'b0;
            eng_result <= 1'b0;
            eng_cnt    <= 0;
            eng_nan    <= 1'b0;
            eng_pinf   <= 1'b0;
            eng_ninf   <= 1'b0;
        end else if (!eng_busy) begin
            eng_busy <= 1'b1;
            eng_op   <= io_bus;
            eng_cnt  <= 0;
        end else if (!eng_mute && !eng_result) begin
            if (eng_cnt == eng_lat) begin
                eng_result <= 1'b1;
                eng_oe     <= 1'b1;
                {eng_nan, eng_pinf, eng_ninf, eng_drv} <= sqrt_model(eng_op);
            end else begin
                eng_cnt <= eng_cnt + 1;
            end
        end
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Offer one request; returns at the negedge after the accepting edge.
    task automatic issue(input string tag, input logic [15:0] op);
        @(negedge clk);
        check_eq({tag, " req_ready"}, 32'(req_ready), 32'd1);
        req_data  = op;
        req_valid = 1'b1;
        @(negedge clk);
        req_valid = 1'b0;
        req_data  = '0;
    endtask

    // Called at the negedge after the accept edge. Latency is counted in edges from acceptance.
    task automatic wait_rsp(input string tag, input logic [15:0] op, input logic [15:0] exp_data,
                            input logic [2:0] exp_flags, input logic exp_tmo, input int exp_lat,
                            input int hold, input bit overlap);
        int lat = 0;
        int drv = 0;
        bit got = 1'b0;
        for (int i = 0; i < 100 && !got; i++) begin
            if (io_bus === op && !eng_oe) drv++;
            if (rsp_valid) begin
                got = 1'b1;
            end else begin
                @(negedge clk);
                lat++;
            end
        end
        check_eq({tag, " rsp_valid seen"}, 32'(got), 32'd1);
        if (!got) return;
        check_eq({tag, " latency"}, 32'(lat), 32'(exp_lat));
        check_eq({tag, " bus drive cycles"}, 32'(drv), 32'd1);
        check_eq({tag, " rsp_data"}, 32'(rsp_data), 32'(exp_data));
        check_eq({tag, " rsp_flags"}, 32'(rsp_flags), 32'(exp_flags));
        check_eq({tag, " rsp_timeout"}, 32'(rsp_timeout), 32'(exp_tmo));
        for (int h = 0; h < hold; h++) begin
            @(negedge clk);
            check_eq({tag, " hold valid"}, 32'(rsp_valid), 32'd1);
            check_eq({tag, " hold data"}, 32'(rsp_data), 32'(exp_data));
            check_eq({tag, " hold req_ready"}, 32'(req_ready), 32'd0);
            check_eq({tag, " hold enable"}, 32'(enable), 32'd0);
        end
        check_eq({tag, " enable in RESP"}, 32'(enable), 32'd0);
        rsp_ready = 1'b1;
        if (overlap) begin
            req_data  = FP16_ONE;
            req_valid = 1'b1;
        end
        @(negedge clk);
        rsp_ready = 1'b0;
        check_eq({tag, " valid dropped"}, 32'(rsp_valid), 32'd0);
        check_eq({tag, " back to idle"}, 32'(req_ready), 32'd1);
        check_eq({tag, " enable in IDLE"}, 32'(enable), 32'd0);
    endtask

    task automatic run_op(input string tag, input logic [15:0] op, input logic [15:0] exp_data,
                          input logic [2:0] exp_flags, input logic exp_tmo, input int exp_lat,
                          input int hold);
        issue(tag, op);
        wait_rsp(tag, op, exp_data, exp_flags, exp_tmo, exp_lat, hold, 1'b0);
    endtask

    initial begin
        int seen;

        // Reset state
        repeat (3) @(negedge clk);
        check_eq("rst enable", 32'(enable), 32'd0);
        check_eq("rst rsp_valid", 32'(rsp_valid), 32'd0);
        check_eq("rst rsp_data", 32'(rsp_data), 32'd0);
        check_eq("rst rsp_flags", 32'(rsp_flags), 32'd0);
        check_eq("rst rsp_timeout", 32'(rsp_timeout), 32'd0);
        check_eq("rst req_ready", 32'(req_ready), 32'd1);
        rst_n = 1'b1;

        // RESULT while idle must be ignored
        @(negedge clk);
        stray_result = 1'b1;
        repeat (2) @(negedge clk);
        stray_result = 1'b0;
        check_eq("stray rsp_valid", 32'(rsp_valid), 32'd0);
        check_eq("stray enable", 32'(enable), 32'd0);
        check_eq("stray req_ready", 32'(req_ready), 32'd1);

        // Normal results: engine answers 2+3 edges after accept
        run_op("one", FP16_ONE, 16'h3C00, 3'b000, 1'b0, 5, 0);
        run_op("two", 16'h4000, 16'h3DA8, 3'b000, 1'b0, 5, 5);
        run_op("pinf", FP16_PINF, 16'h7C00, 3'b010, 1'b0, 5, 0);
        run_op("qnan", FP16_QNAN, 16'h7E00, 3'b100, 1'b0, 5, 0);

        // Silent engine: 32 WAIT cycles after the DRIVE cycle
        eng_mute = 1'b1;
        run_op("tmo", FP16_ONE, 16'h0000, 3'b000, 1'b1, 33, 0);
        eng_mute = 1'b0;

        // Result on the timeout edge wins; one edge later it is too late
        eng_lat = 30;
        run_op("edge win", 16'h4000, 16'h3DA8, 3'b000, 1'b0, 33, 0);
        eng_lat = 31;
        run_op("edge late", 16'h4000, 16'h0000, 3'b000, 1'b1, 33, 0);
        eng_lat = 2;

        // New request offered while the response is consumed: accepted only from IDLE
        issue("ovl", FP16_PINF);
        wait_rsp("ovl", FP16_PINF, 16'h7C00, 3'b010, 1'b0, 5, 0, 1'b1);
        @(negedge clk);
        req_valid = 1'b0;
        req_data  = '0;
        check_eq("ovl accepted enable", 32'(enable), 32'd1);
        check_eq("ovl accepted req_ready", 32'(req_ready), 32'd0);
        wait_rsp("ovl next", FP16_ONE, 16'h3C00, 3'b000, 1'b0, 5, 0, 1'b0);

        // Reset in the middle of WAIT drops the request
        issue("rst", FP16_ONE);
        repeat (2) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check_eq("mid rst enable", 32'(enable), 32'd0);
        check_eq("mid rst bus released", 32'(io_bus === FP16_ONE), 32'd0);
        check_eq("mid rst rsp_valid", 32'(rsp_valid), 32'd0);
        check_eq("mid rst rsp_data", 32'(rsp_data), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        seen = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (rsp_valid || enable) seen++;
        end
        check_eq("dropped no response", 32'(seen), 32'd0);
        run_op("after rst", FP16_ONE, 16'h3C00, 3'b000, 1'b0, 5, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global time limit: got running expected finished");
        $fatal(1, "time limit");
    end

endmodule
